// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared types and constants for the mips core and its boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int         c_addr_w = 10;
    localparam int         c_data_w = 32;
    localparam logic [5:0] c_hlt_op = 6'h3f;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DUMP  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_dump_rd.sv
`default_nettype none
// ============================================================================
// Module   : mips_dump_rd
// Brief    : Dump-window read issue and single output register for the loader.
// Revision : 1.0 - initial release
// ============================================================================
module mips_dump_rd
    import mips_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_init,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [7:0]        i_len,
    output logic              o_rd_re,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_last,
    output logic              o_last_done
);

    logic [ADDR_W-1:0] r_base;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic              r_inflight;
    logic              r_last_pend;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    logic w_issue;
    logic w_hs;

    // A read may only be issued when its result has somewhere to land next cycle.
    assign w_issue     = i_en && !r_inflight && (r_cnt < r_len) && (!r_valid || i_m_ready);
    assign w_hs        = r_valid && i_m_ready;
    assign o_rd_re     = w_issue;
    assign o_rd_addr   = r_base + ADDR_W'(r_cnt);
    assign o_m_valid   = r_valid;
    assign o_m_data    = r_data;
    assign o_m_last    = r_last;
    assign o_last_done = w_hs && r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_inflight  <= 1'b0;
            r_last_pend <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
        end else if (i_init) begin
            r_base      <= i_base;
            r_len       <= i_len;
            r_cnt       <= '0;
            r_inflight  <= 1'b0;
            r_last_pend <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_cnt       <= r_cnt + 8'd1;
                r_last_pend <= (r_cnt == r_len - 8'd1);
            end
            // Capture never coincides with a pending beat: issue required an empty slot.
            if (r_inflight) begin
                r_valid <= 1'b1;
                r_data  <= i_rd_data;
                r_last  <= r_last_pend;
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : mips_boot_loader
// Brief    : Streams an image into core memory, starts the core, dumps results.
// Revision : 1.0 - initial release
// ============================================================================
module mips_boot_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_start,
    input  logic              core_halted,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [7:0]        dump_len,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_err;

    logic              w_load_hs;
    logic              w_wr_full;
    logic              w_dump_init;
    logic              w_rd_re;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_last_done;

    assign w_load_hs = (r_state == LOAD) && s_valid;
    assign w_wr_full = &r_wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wr_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // The write counter saturates so address 0 is never overwritten.
            if (w_load_hs && !s_last) begin
                if (w_wr_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        core_start  = 1'b0;
        w_dump_init = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && (s_last || w_wr_full)) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                core_start  = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (core_halted) begin
                    w_dump_init = 1'b1;
                    w_state_nxt = (dump_len == 8'd0) ? DONE : DUMP;
                end
            end
            DUMP: begin
                if (w_last_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    mips_dump_rd #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dump_rd (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (r_state == DUMP),
        .i_init      (w_dump_init),
        .i_base      (dump_base),
        .i_len       (dump_len),
        .o_rd_re     (w_rd_re),
        .o_rd_addr   (w_rd_addr),
        .i_rd_data   (mem_rdata),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_data    (m_data),
        .o_m_last    (m_last),
        .o_last_done (w_last_done)
    );

    assign mem_we    = w_load_hs;
    assign mem_wdata = w_load_hs ? s_data : '0;
    assign mem_re    = w_rd_re;
    assign mem_addr  = (r_state == LOAD) ? r_wr_cnt : (w_rd_re ? w_rd_addr : '0);
    assign busy      = (r_state != IDLE) && (r_state != DONE);
    assign done      = (r_state == DONE);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_boot_loader
// Brief    : Directed plus randomized bench with a memory model and reference image.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mips_boot_loader;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          core_start, core_halted;
    logic [AW-1:0] dump_base;
    logic [7:0]    dump_len;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;
    logic          busy, done, err;

    logic          core_we;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] img     [0:1100];

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int a0_cnt = 0;
    int rd_q[$];

    always #5 clk = ~clk;

    mips_boot_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_start(core_start), .core_halted(core_halted),
        .dump_base(dump_base), .dump_len(dump_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .err(err)
    );

    // Core memory model: data is only meaningful the cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (core_we) mem[core_waddr] <= core_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= $urandom;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                we_cnt++;
                if (mem_addr == '0) a0_cnt++;
            end
            if (mem_re) rd_q.push_back(int'(mem_addr));
            if (mem_we || mem_re) begin
                tests++;
                assert (!(mem_we && mem_re)) else begin
                    fails++;
                    $error("FAIL strobe_excl: observed we=%0b re=%0b expected not both", mem_we, mem_re);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_re"}, mem_re, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        core_halted = 1'b0; core_we = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        #1;
        chk("rst_idle_busy", busy, 0);
        chk("rst_idle_ready", s_ready, 0);
        @(negedge clk);
        chk("rst_load_ready", s_ready, 1);
        chk("rst_load_busy", busy, 1);
    endtask

    task automatic load_img(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                tick(); s_valid = 1'b0; s_data = $urandom; s_last = 1'b0;
                @(negedge clk);
                chk("gap_we", mem_we, 0);
            end
            tick(); s_valid = 1'b1; s_data = img[i]; s_last = (i == n - 1);
            @(negedge clk);
            chk("ld_we", mem_we, 1);
            chk("ld_addr", mem_addr, i);
            chk("ld_wdata", mem_wdata, img[i]);
            chk("ld_nostart", core_start, 0);
            ref_mem[i] = img[i];
        end
        tick(); s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("start_pulse", core_start, 1);
        chk("start_ready", s_ready, 0);
        tick();
        @(negedge clk);
        chk("start_once", core_start, 0);
        chk("run_busy", busy, 1);
    endtask

    task automatic run_dump(input int base, input int len, input bit stall);
        int j = 0;
        int vcnt = 0;
        int budget = 0;
        bit held = 1'b0;
        logic [31:0] hd = '0;
        logic hl = 1'b0;
        rd_q.delete();
        tick(); dump_base = AW'(base); dump_len = 8'(len); core_halted = 1'b1; m_ready = 1'b0;
        @(negedge clk);
        while (j < len && budget < 400) begin
            tick();
            m_ready = stall ? (vcnt >= 5) : 1'($urandom_range(0, 1));
            @(negedge clk);
            budget++;
            if (m_valid) begin
                if (held) begin
                    chk("hold_data", m_data, hd);
                    chk("hold_last", m_last, hl);
                end
                if (m_ready) begin
                    chk("dump_data", m_data, ref_mem[(base + j) % 1024]);
                    chk("dump_last", m_last, (j == len - 1));
                    j++; vcnt = 0; held = 1'b0;
                end else begin
                    vcnt++; held = 1'b1; hd = m_data; hl = m_last;
                end
            end else if (held) begin
                chk("hold_valid", m_valid, 1);
                held = 1'b0;
            end
        end
        chk("dump_count", j, len);
        tick(); m_ready = 1'b0; core_halted = 1'b0;
        @(negedge clk);
        chk("dump_done", done, 1);
        chk("dump_notbusy", busy, 0);
        chk("dump_novalid", m_valid, 0);
        chk("dump_nreads", rd_q.size(), len);
        for (int k = 0; k < rd_q.size() && k < len; k++) begin
            chk("dump_raddr", rd_q[k], (base + k) % 1024);
        end
    endtask

    initial begin
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        core_halted = 1'b0; dump_base = '0; dump_len = '0;
        core_we = 1'b0; core_waddr = '0; core_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

        // Program image; the core stand-in stores word120 + 45 into word 121.
        do_reset();
        for (int i = 0; i < 122; i++) img[i] = '0;
        img[0] = 32'h28010078; img[1] = 32'h0c631800; img[2] = 32'h20220000;
        img[3] = 32'h0c631800; img[4] = 32'h2842002d; img[5] = 32'h0c631800;
        img[6] = 32'h24220001; img[7] = 32'hfc000000; img[120] = 32'd95;
        load_img(122, 1'b0);
        repeat (3) begin
            tick();
            @(negedge clk);
            chk("run_wait_busy", busy, 1);
            chk("run_wait_novalid", m_valid, 0);
        end
        tick(); core_we = 1'b1; core_waddr = 10'd121; core_wdata = 32'd140;
        ref_mem[121] = 32'd140;
        tick(); core_we = 1'b0;
        m_ready = 1'b1; dump_base = 10'd120; dump_len = 8'd2; core_halted = 1'b1;
        @(negedge clk);
        chk("a_halt_nore", mem_re, 0);
        tick(); @(negedge clk);
        chk("a_re0", mem_re, 1);
        chk("a_raddr0", mem_addr, 120);
        chk("a_v_k0", m_valid, 0);
        tick(); @(negedge clk);
        chk("a_v_k1", m_valid, 0);
        chk("a_re_k1", mem_re, 0);
        tick(); @(negedge clk);
        chk("a_v_k2", m_valid, 1);
        chk("a_data0", m_data, 95);
        chk("a_last0", m_last, 0);
        chk("a_re1", mem_re, 1);
        chk("a_raddr1", mem_addr, 121);
        tick(); @(negedge clk);
        chk("a_v_k3", m_valid, 0);
        tick(); @(negedge clk);
        chk("a_v_k4", m_valid, 1);
        chk("a_data1", m_data, 140);
        chk("a_last1", m_last, 1);
        tick(); core_halted = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        chk("a_done", done, 1);
        chk("a_notbusy", busy, 0);
        chk("a_novalid", m_valid, 0);
        repeat (3) begin
            tick(); s_valid = 1'b1; s_data = $urandom;
            @(negedge clk);
            chk("a_done_sticky", done, 1);
            chk("a_done_noready", s_ready, 0);
            chk("a_done_nowe", mem_we, 0);
        end
        tick(); s_valid = 1'b0;

        // Gapped 4-beat load followed by an empty dump window.
        do_reset();
        we_cnt = 0;
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        load_img(4, 1'b1);
        chk("b_we_cnt", we_cnt, 4);
        rd_q.delete();
        tick(); dump_len = 8'd0; dump_base = 10'd5; core_halted = 1'b1;
        @(negedge clk);
        chk("b_done_pre", done, 0);
        tick(); @(negedge clk);
        chk("b_done", done, 1);
        chk("b_notbusy", busy, 0);
        repeat (4) begin
            tick(); @(negedge clk);
            chk("b_novalid", m_valid, 0);
        end
        chk("b_noreads", rd_q.size(), 0);
        core_halted = 1'b0;

        // Image overflow: 1025 beats, s_last only on the final one.
        do_reset();
        a0_cnt = 0;
        for (int i = 0; i < 1025; i++) begin
            logic [31:0] beat;
            beat = $urandom;
            tick(); s_valid = 1'b1; s_data = beat; s_last = (i == 1024);
            @(negedge clk);
            if (i < 1024) begin
                chk("ov_we", mem_we, 1);
                chk("ov_addr", mem_addr, i);
                ref_mem[i] = beat;
                if (i == 1023) chk("ov_err_pre", err, 0);
            end else begin
                chk("ov_start", core_start, 1);
                chk("ov_err", err, 1);
                chk("ov_we_blocked", mem_we, 0);
                chk("ov_noready", s_ready, 0);
            end
        end
        tick(); s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("ov_start_once", core_start, 0);
        chk("ov_err_sticky", err, 1);
        chk("ov_busy", busy, 1);
        chk("ov_a0_once", a0_cnt, 1);
        chk("ov_mem0", mem[0], ref_mem[0]);

        // Wrapping dump window with a 5-cycle stall on every beat.
        run_dump(1022, 4, 1'b1);
        chk("d_err_sticky", err, 1);

        // Randomized short images and dump windows.
        for (int it = 0; it < 3; it++) begin
            int n;
            n = $urandom_range(3, 12);
            do_reset();
            for (int i = 0; i < n; i++) img[i] = $urandom;
            load_img(n, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 4)) tick();
            run_dump($urandom_range(0, 1023), $urandom_range(1, 8), 1'b0);
        end

        // Reset asserted mid-dump, then a fresh 2-word load.
        do_reset();
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        load_img(3, 1'b0);
        tick(); dump_base = 10'd0; dump_len = 8'd3; core_halted = 1'b1; m_ready = 1'b0;
        repeat (4) begin
            tick(); @(negedge clk);
        end
        chk("f_dump_busy", busy, 1);
        chk("f_dump_valid", m_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("f_rst");
        core_halted = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("f_idle_busy", busy, 0);
        @(negedge clk);
        chk("f_load_ready", s_ready, 1);
        for (int i = 0; i < 2; i++) img[i] = $urandom;
        load_img(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_boot_loader.md
# mips_boot_loader

Single-clock boot and result-dump controller sitting directly upstream of the `mips` pipeline core. It streams a program and data image into the core's unified memory through a dedicated write port, then releases the core from address 0. It waits for the core to halt and streams a selected memory window back out. It replaces hierarchical preload and peek of `Mem`, `PC`, `HALTED` and `TAKEN_BRANCH`, so the core can be exercised as a closed block.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of core memory (1024 words).
- `DATA_W`, 32: memory and stream word width.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  load-stream beat valid.
- `s_ready`  out  1  loader accepts beat.
- `s_data`  in  DATA_W  word to store.
- `s_last`  in  1  final beat of image.
- `mem_we`  out  1  core memory write strobe.
- `mem_re`  out  1  core memory read strobe.
- `mem_addr`  out  ADDR_W  word address for write or read.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `mem_re`.
- `core_start`  out  1  1-cycle pulse: core sets PC=0, HALTED=0, TAKEN_BRANCH=0 and runs.
- `core_halted`  in  1  core has retired HLT (6'h3f).
- `dump_base`  in  ADDR_W  first dump address, sampled on `core_halted`.
- `dump_len`  in  8  number of words to dump, sampled with `dump_base`.
- `m_valid`, `m_ready`, `m_data[DATA_W]`, `m_last`: dump stream; directions are out, in, out, out.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  sticky high after the dump completes.
- `err`  out  1  sticky: image overflowed memory.

## Operation
- State IDLE: entered asynchronously while `rst_n`=0. On the first clock after deassertion, move to LOAD.
- State LOAD:
  - `s_ready`=1 (combinational from state).
  - Each handshake (`s_valid && s_ready`) drives `mem_we`=1, `mem_addr`=wr_cnt and `mem_wdata`=`s_data` in that same cycle, then increments wr_cnt.
  - A beat with `s_last`=1 moves to START.
  - A beat written at address 2^ADDR_W−1 without `s_last` also moves to START and sets `err`. The counter never wraps, so address 0 is never overwritten.
- State START: `core_start`=1 for exactly one cycle, then RUN.
- State RUN: wait for `core_halted`=1.
  - Sample `dump_base` and `dump_len`, clear rd_cnt and go to DUMP.
  - If `dump_len`=0, go directly to DONE; `m_valid` never rises.
- State DUMP: one output register, no skid buffer.
  - Issue `mem_re` with `mem_addr`=(base+rd_cnt) mod 2^ADDR_W only when no read is in flight and (`m_valid`=0 or `m_ready`=1).
  - The next cycle captures `mem_rdata` into `m_data` and sets `m_valid`. `m_last` is set when rd_cnt = len−1.
  - `m_data`, `m_valid` and `m_last` are held stable while `m_ready`=0.
  - After the last beat handshakes, go to DONE.
- State DONE: `done`=1. The block stays here until reset; the stream inputs are ignored.
- `mem_we` and `mem_re` are never high together. No memory strobe is driven outside LOAD and DUMP.
- Reset at any point clears the state, counters and every output. Memory contents are not touched.

## Timing
- Reset values: `s_ready`, `mem_we`, `mem_re`, `mem_addr`, `mem_wdata`, `core_start`, `m_valid`, `m_data`, `m_last`, `busy`, `done` and `err` are all 0.
- Load: one word per cycle, zero-latency write. Back-to-back `s_valid` gives full throughput.
- Start: `core_start` rises the cycle after the last load handshake.
- Dump latency: `m_valid` rises 2 cycles after entering DUMP.
- Dump throughput: with `m_ready` held high, one word every 2 cycles.
- `core_halted` is sampled only in RUN. If it is already high on entering RUN, DUMP is entered on the next cycle.

## Structure
- Shared package `mips_pkg`:
  - state enum {IDLE, LOAD, START, RUN, DUMP, DONE};
  - HLT opcode constant 6'h3f;
  - default ADDR_W/DATA_W constants reused by the core.
- Optional sub-module `mips_dump_rd`: the read-issue and output-register logic of DUMP.
- The top FSM and load counter live in `mips_boot_loader`.

## Test plan
- Load 122 words: words 0–7 = 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000; words 8–119 zero; word 120 = 95 (decimal). Set `dump_base`=120 and `dump_len`=2 with the real core attached. Required: after halt, the outputs are 95 then 140, and `m_last` is high on 140.
- `s_valid` toggled every other cycle across 4 beats: exactly 4 `mem_we` pulses at addresses 0..3; `core_start` rises exactly 1 cycle after beat 3.
- 1025 beats with `s_last` only on the last: `err`=1 after beat 1023; `core_start` follows; address 0 is never rewritten.
- Halted core model, `dump_base`=1022, `dump_len`=4, `m_ready` low for 5 cycles per beat: reads at 1022, 1023, 0, 1; data held stable while stalled.
- `dump_len`=0: `done` rises the cycle after halt is seen, with no `m_valid`.
- `rst_n` pulsed low mid-DUMP: all outputs 0 immediately, return to LOAD; a reload of 2 words writes addresses 0 and 1.
